// File: rtl/single_port_ram_8x8_pkg.sv
// -----------------------------------------------------------------------------
// mbank_pkg
// Shared constants and types for the memory-bank subsystem.
//   MBANK_DATA_WIDTH : width of one stored word
//   MBANK_DEPTH      : number of words per bank
//   MBANK_ADDR_WIDTH : width of a word address
//   mbank_addr_t     : word address type
//   mbank_data_t     : data word type
// -----------------------------------------------------------------------------
package mbank_pkg;

    localparam int MBANK_DATA_WIDTH = 8;
    localparam int MBANK_DEPTH      = 8;
    localparam int MBANK_ADDR_WIDTH = $clog2(MBANK_DEPTH);

    typedef logic [MBANK_ADDR_WIDTH-1:0] mbank_addr_t;
    typedef logic [MBANK_DATA_WIDTH-1:0] mbank_data_t;

endpackage : mbank_pkg

// File: rtl/single_port_ram_8x8_if.sv
// -----------------------------------------------------------------------------
// single_port_ram_8x8_if
// Access bus of one memory bank.
//   en   : bank enable (master -> slave)
//   we   : 1 = write, 0 = read, qualified by en (master -> slave)
//   addr : word address (master -> slave)
//   din  : write data (master -> slave)
//   dout : registered read data (slave -> master)
//
// Handshake: en acts as the request valid and there is no ready; the bank
// accepts every request on the rising edge where en=1. A read's data is
// valid on dout after that edge and stays there until the next accepted
// read or a reset.
// -----------------------------------------------------------------------------
interface single_port_ram_8x8_if
    import mbank_pkg::*;
#(
    parameter int DATA_WIDTH = MBANK_DATA_WIDTH,
    parameter int ADDR_WIDTH = MBANK_ADDR_WIDTH
);

    logic                  en;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;

    modport master (
        output en,
        output we,
        output addr,
        output din,
        input  dout
    );

    modport slave (
        input  en,
        input  we,
        input  addr,
        input  din,
        output dout
    );

endinterface : single_port_ram_8x8_if

// File: rtl/single_port_ram_8x8.sv
// -----------------------------------------------------------------------------
// single_port_ram_8x8
// Synchronous single-port RAM bank with a registered read port
// (one-cycle read latency). Leaf storage of the memory-bank subsystem.
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset; clears dout and every word
//   bus   : slave side of single_port_ram_8x8_if (en, we, addr, din, dout)
// -----------------------------------------------------------------------------
module single_port_ram_8x8
    import mbank_pkg::*;
#(
    parameter int DATA_WIDTH = MBANK_DATA_WIDTH,
    parameter int DEPTH      = MBANK_DEPTH,
    parameter int ADDR_WIDTH = MBANK_ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    single_port_ram_8x8_if.slave   bus
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] dout_q;
    logic [DATA_WIDTH-1:0] dout_d;

    logic                  wr_en;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] addr;

    assign addr  = bus.addr;
    assign wr_en = bus.en &  bus.we;
    assign rd_en = bus.en & ~bus.we;

    // Next state: a write updates only the addressed word and leaves dout
    // alone (no write-through); a read loads dout from the stored array, so
    // a read one edge after a write already sees the new word.
    always_comb begin
        mem_d  = mem_q;
        dout_d = dout_q;
        if (wr_en) begin
            mem_d[addr] = bus.din;
        end
        if (rd_en) begin
            dout_d = mem_q[addr];
        end
    end

    // Reset clears the whole array as well as dout, so every location reads
    // back 0 until written and no X can leave the bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            dout_q <= dout_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign bus.dout = dout_q;

endmodule : single_port_ram_8x8

// File: tb/tb_single_port_ram_8x8.sv
// -----------------------------------------------------------------------------
// tb_single_port_ram_8x8
// Directed bench for single_port_ram_8x8 with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_single_port_ram_8x8;
    import mbank_pkg::*;

    localparam int W = MBANK_DATA_WIDTH;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_q[$];

    single_port_ram_8x8_if bus_if ();

    single_port_ram_8x8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [W-1:0] act,
                            input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 8'h%02h, expected 8'h%02h", tag, act, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive_idle();
        @(negedge clk);
        bus_if.en   = 1'b0;
        bus_if.we   = 1'b0;
        bus_if.addr = '0;
        bus_if.din  = '0;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [W-1:0] d);
        @(negedge clk);
        bus_if.en   = 1'b1;
        bus_if.we   = 1'b1;
        bus_if.addr = a;
        bus_if.din  = d;
        @(posedge clk);
        #1;
    endtask

    // Read and compare dout against the value queued by the caller.
    task automatic do_read(input string tag, input logic [2:0] a);
        logic [W-1:0] e;
        @(negedge clk);
        bus_if.en   = 1'b1;
        bus_if.we   = 1'b0;
        bus_if.addr = a;
        bus_if.din  = 8'hEE;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            check_eq(tag, bus_if.dout, e);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus_if.en   = 1'b0;
        bus_if.we   = 1'b0;
        bus_if.addr = '0;
        bus_if.din  = '0;
        rst_n       = 1'b0;

        // Reset: dout 0 during reset, then every word reads 0.
        #1;
        check_eq("dout_in_reset", bus_if.dout, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        check_eq("dout_in_reset_2cyc", bus_if.dout, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'h00);
            do_read($sformatf("reset_rd%0d", i), 3'(i));
        end

        // Fill / readback.
        for (int i = 0; i < 8; i++) begin
            do_write(3'(i), 8'(i));
            exp_q.push_back(8'(i));
            do_read($sformatf("fill_rd%0d", i), 3'(i));
        end

        // Enable gating.
        do_write(3'd3, 8'hA5);
        exp_q.push_back(8'h00);
        do_read("gate_pre_rd0", 3'd0);
        @(negedge clk);
        bus_if.en   = 1'b0;
        bus_if.we   = 1'b1;
        bus_if.addr = 3'd3;
        bus_if.din  = 8'hFF;
        @(posedge clk);
        #1;
        check_eq("gate_wr_dout_hold", bus_if.dout, 8'h00);
        @(negedge clk);
        bus_if.we = 1'b0;
        @(posedge clk);
        #1;
        check_eq("gate_rd_dout_hold", bus_if.dout, 8'h00);
        exp_q.push_back(8'hA5);
        do_read("gate_rd3", 3'd3);

        // Write holds dout.
        exp_q.push_back(8'h07);
        do_read("hold_rd7_old", 3'd7);
        do_write(3'd7, 8'h04);
        check_eq("hold_dout_on_wr", bus_if.dout, 8'h07);
        exp_q.push_back(8'h04);
        do_read("hold_rd7_new", 3'd7);

        // Back-to-back write then read on adjacent edges.
        do_write(3'd5, 8'h3C);
        exp_q.push_back(8'h3C);
        do_read("b2b_rd5", 3'd5);

        // Mid-operation reset between edges while a read is being driven.
        @(negedge clk);
        bus_if.en   = 1'b1;
        bus_if.we   = 1'b0;
        bus_if.addr = 3'd6;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_dout_async", bus_if.dout, 8'h00);
        @(posedge clk);
        #1;
        check_eq("midrst_dout_hold", bus_if.dout, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(8'h00);
        do_read("midrst_rd6", 3'd6);
        exp_q.push_back(8'h00);
        do_read("midrst_rd5", 3'd5);

        drive_idle();
        repeat (2) @(posedge clk);

        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_leftover: %0d entries remain, expected 0",
                     exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_single_port_ram_8x8
